// File: rtl/int_isq_mport.sv
// ----------------------------------------------------------------------------
// int_isq_mport
//   Multi-port integer issue queue sitting between rename/dispatch and the
//   integer ALU pipes. Up to ENQ_PORTS entries are dispatched per cycle, up to
//   DEQ_PORTS ready entries are issued per cycle in age order (oldest first),
//   UPD_PORTS wakeup channels overwrite source-ready bits by robid, and a
//   flush kills every entry strictly younger than the flush robid.
//
//   Payload never moves once written; age is tracked by a DEPTH x DEPTH
//   matrix where age_q[i][j] = 1 means entry j is older than entry i.
//
// Ports
//   clock, reset_n                     clock, async active-low reset
//   enq_valid/enq_ready                per-port dispatch handshake
//   enq_data/condition/index/robid     flattened per-port dispatch fields
//   deq_valid/deq_ready                per-port issue handshake
//   deq_data/condition/index/robid     flattened per-port issued fields
//   update_condition_valid/robid/mask/in  wakeup broadcast channels
//   flush_valid, flush_robid           flush strobe and flush point
//   isq_count                          registered count of valid entries
// ----------------------------------------------------------------------------
module int_isq_mport #(
    parameter  int DATA_WIDTH      = 248,
    parameter  int CONDITION_WIDTH = 2,
    parameter  int INDEX_WIDTH     = 4,
    parameter  int DEPTH           = 8,
    parameter  int ENQ_PORTS       = 2,
    parameter  int DEQ_PORTS       = 2,
    parameter  int UPD_PORTS       = 2,
    parameter  int ROB_SIZE_LOG    = 6,
    localparam int RW              = ROB_SIZE_LOG + 1,
    localparam int CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [ENQ_PORTS-1:0]                 enq_valid,
    output logic [ENQ_PORTS-1:0]                 enq_ready,
    input  logic [ENQ_PORTS*DATA_WIDTH-1:0]      enq_data,
    input  logic [ENQ_PORTS*CONDITION_WIDTH-1:0] enq_condition,
    input  logic [ENQ_PORTS*INDEX_WIDTH-1:0]     enq_index,
    input  logic [ENQ_PORTS*RW-1:0]              enq_robid,
    output logic [DEQ_PORTS-1:0]                 deq_valid,
    input  logic [DEQ_PORTS-1:0]                 deq_ready,
    output logic [DEQ_PORTS*DATA_WIDTH-1:0]      deq_data,
    output logic [DEQ_PORTS*CONDITION_WIDTH-1:0] deq_condition,
    output logic [DEQ_PORTS*INDEX_WIDTH-1:0]     deq_index,
    output logic [DEQ_PORTS*RW-1:0]              deq_robid,
    input  logic [UPD_PORTS-1:0]                 update_condition_valid,
    input  logic [UPD_PORTS*RW-1:0]              update_condition_robid,
    input  logic [UPD_PORTS*CONDITION_WIDTH-1:0] update_condition_mask,
    input  logic [UPD_PORTS*CONDITION_WIDTH-1:0] update_condition_in,
    input  logic                                 flush_valid,
    input  logic [RW-1:0]                        flush_robid,
    output logic [CNT_W-1:0]                     isq_count
);

    localparam int CW = CONDITION_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int IW = INDEX_WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic [CW-1:0]    cond_q  [DEPTH];
    logic [CW-1:0]    cond_d  [DEPTH];
    logic [DW-1:0]    data_q  [DEPTH];
    logic [IW-1:0]    index_q [DEPTH];
    logic [RW-1:0]    robid_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] kill;        // entries flushed at this edge
    logic [DEPTH-1:0] ready;       // issuable this cycle (flush-masked)
    logic [CNT_W-1:0] rank [DEPTH];// number of older ready entries
    logic [DEPTH-1:0] fire;        // entries leaving through an issue port
    logic [DEPTH-1:0] dealloc;
    logic [DEPTH-1:0] survive;

    logic [CNT_W-1:0] free_cnt;
    logic [ENQ_PORTS-1:0] accept;
    logic [DEPTH-1:0] alloc_oh  [ENQ_PORTS]; // slot chosen by each port
    logic [DEPTH-1:0] older_new [ENQ_PORTS]; // slots taken by earlier ports
    logic [DEPTH-1:0] claimed;

    // Robid age compare; the MSB is the ROB wrap bit, so when wrap bits
    // differ the numerically smaller low part is the younger one.
    function automatic logic younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] != b[RW-1]) return a[RW-2:0] < b[RW-2:0];
        return a[RW-2:0] > b[RW-2:0];
    endfunction

    // Apply all matching wakeup channels in channel order, so a higher
    // channel wins on overlapping mask bits.
    function automatic logic [CW-1:0] wake(input logic [RW-1:0] rob, input logic [CW-1:0] cond_in);
        logic [CW-1:0] c;
        c = cond_in;
        for (int u = 0; u < UPD_PORTS; u++) begin
            if (update_condition_valid[u] && (update_condition_robid[u*RW +: RW] == rob)) begin
                c = (c & ~update_condition_mask[u*CW +: CW]) |
                    (update_condition_in[u*CW +: CW] & update_condition_mask[u*CW +: CW]);
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Flush kill, readiness and age rank (from registered state only, so
    // a wakeup never reaches deq_valid in the same cycle)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first; a path
        // that skips an assignment would otherwise infer a latch.
        kill  = '0;
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i]  = flush_valid && valid_q[i] && younger(robid_q[i], flush_robid);
            ready[i] = valid_q[i] && (&cond_q[i]) && !kill[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            rank[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && age_q[i][j]) rank[i] = rank[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue select: port k presents the ready entry with exactly k older
    // ready entries. Ranks among ready entries are unique, so no entry can
    // appear on two ports.
    // ------------------------------------------------------------------
    always_comb begin
        deq_valid     = '0;
        deq_data      = '0;
        deq_condition = '0;
        deq_index     = '0;
        deq_robid     = '0;
        fire          = '0;
        for (int k = 0; k < DEQ_PORTS; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ready[i] && (rank[i] == CNT_W'(k))) begin
                    deq_valid[k]                 = 1'b1;
                    deq_data[k*DW +: DW]         = data_q[i];
                    deq_condition[k*CW +: CW]    = cond_q[i];
                    deq_index[k*IW +: IW]        = index_q[i];
                    deq_robid[k*RW +: RW]        = robid_q[i];
                    fire[i]                      = deq_ready[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Enqueue: readiness uses only the free count at cycle start; accepted
    // ports take the lowest free slots in port order.
    // ------------------------------------------------------------------
    always_comb begin
        free_cnt = CNT_W'(DEPTH) - count_q;
        for (int p = 0; p < ENQ_PORTS; p++) begin
            enq_ready[p] = !flush_valid && (free_cnt > CNT_W'(p));
        end
        accept  = enq_valid & enq_ready;
        claimed = '0;
        for (int p = 0; p < ENQ_PORTS; p++) begin
            alloc_oh[p]  = '0;
            older_new[p] = claimed;
            for (int s = 0; s < DEPTH; s++) begin
                if (accept[p] && !valid_q[s] && !claimed[s] && (alloc_oh[p] == '0)) begin
                    alloc_oh[p][s] = 1'b1;
                end
            end
            claimed = claimed | alloc_oh[p];
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        dealloc = fire | kill;
        survive = valid_q & ~dealloc;
        valid_d = survive | claimed;

        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (dealloc[i]) count_d = count_d - CNT_W'(1);
        end
        for (int p = 0; p < ENQ_PORTS; p++) begin
            if (accept[p]) count_d = count_d + CNT_W'(1);
        end

        for (int i = 0; i < DEPTH; i++) begin
            // Leaving entries clear their row and their column everywhere.
            age_d[i]  = dealloc[i] ? '0 : (age_q[i] & ~dealloc);
            cond_d[i] = wake(robid_q[i], cond_q[i]);
            for (int p = 0; p < ENQ_PORTS; p++) begin
                if (alloc_oh[p][i]) begin
                    // New entry is younger than every survivor and than
                    // entries placed by lower-numbered ports this cycle.
                    age_d[i]  = survive | older_new[p];
                    cond_d[i] = wake(enq_robid[p*RW +: RW], enq_condition[p*CW +: CW]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers sample their _d values from the same pre-edge snapshot.
        if (!reset_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    // NOTE: the entry storage has no reset; every read of it is gated by
    // valid_q, so stale contents are never observable and the arrays stay
    // plain flops/RAM without a reset network.
    always_ff @(posedge clock) begin
        for (int s = 0; s < DEPTH; s++) begin
            cond_q[s] <= cond_d[s];
            for (int p = 0; p < ENQ_PORTS; p++) begin
                if (alloc_oh[p][s]) begin
                    data_q[s]  <= enq_data[p*DW +: DW];
                    index_q[s] <= enq_index[p*IW +: IW];
                    robid_q[s] <= enq_robid[p*RW +: RW];
                end
            end
        end
    end

    assign isq_count = count_q;

endmodule

// File: tb/tb_int_isq_mport.sv
// ----------------------------------------------------------------------------
// tb_int_isq_mport
//   Bench for int_isq_mport. A reference model keeps the resident entries as
//   an age-ordered list; every cycle the driver derives the expected outputs
//   from it and queues them, and a monitor on the falling edge pops and
//   compares against the DUT. Directed scenarios add explicit checks.
// ----------------------------------------------------------------------------
module tb_int_isq_mport;

    localparam int DW    = 248;
    localparam int CW    = 2;
    localparam int IW    = 4;
    localparam int DEPTH = 8;
    localparam int EP    = 2;
    localparam int DP    = 2;
    localparam int UP    = 2;
    localparam int RW    = 7;
    localparam int CNTW  = 4;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic [EP-1:0]        enq_valid, enq_ready;
    logic [EP*DW-1:0]     enq_data;
    logic [EP*CW-1:0]     enq_condition;
    logic [EP*IW-1:0]     enq_index;
    logic [EP*RW-1:0]     enq_robid;
    logic [DP-1:0]        deq_valid, deq_ready;
    logic [DP*DW-1:0]     deq_data;
    logic [DP*CW-1:0]     deq_condition;
    logic [DP*IW-1:0]     deq_index;
    logic [DP*RW-1:0]     deq_robid;
    logic [UP-1:0]        update_condition_valid;
    logic [UP*RW-1:0]     update_condition_robid;
    logic [UP*CW-1:0]     update_condition_mask;
    logic [UP*CW-1:0]     update_condition_in;
    logic                 flush_valid;
    logic [RW-1:0]        flush_robid;
    logic [CNTW-1:0]      isq_count;

    always #5 clock = ~clock;

    int_isq_mport dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .enq_valid              (enq_valid),
        .enq_ready              (enq_ready),
        .enq_data               (enq_data),
        .enq_condition          (enq_condition),
        .enq_index              (enq_index),
        .enq_robid              (enq_robid),
        .deq_valid              (deq_valid),
        .deq_ready              (deq_ready),
        .deq_data               (deq_data),
        .deq_condition          (deq_condition),
        .deq_index              (deq_index),
        .deq_robid              (deq_robid),
        .update_condition_valid (update_condition_valid),
        .update_condition_robid (update_condition_robid),
        .update_condition_mask  (update_condition_mask),
        .update_condition_in    (update_condition_in),
        .flush_valid            (flush_valid),
        .flush_robid            (flush_robid),
        .isq_count              (isq_count)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: resident entries, oldest first
    // ------------------------------------------------------------------
    typedef struct {
        int            seq;
        logic [RW-1:0] rob;
        logic [CW-1:0] cond;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } ent_t;

    typedef struct {
        logic [EP-1:0]           enq_ready;
        logic [DP-1:0]           deq_valid;
        logic [CNTW-1:0]         count;
        logic [DP-1:0][RW-1:0]   rob;
        logic [DP-1:0][DW-1:0]   data;
        logic [DP-1:0][CW-1:0]   cond;
        logic [DP-1:0][IW-1:0]   idx;
    } exp_t;

    ent_t model[$];
    exp_t sb[$];
    int   sel[DP];
    logic [EP-1:0] cur_ready;
    int   seq = 0;

    // Current-cycle stimulus
    logic [EP-1:0] s_ev;
    logic [DW-1:0] s_ed [EP];
    logic [CW-1:0] s_ec [EP];
    logic [IW-1:0] s_ei [EP];
    logic [RW-1:0] s_er [EP];
    logic [DP-1:0] s_dr;
    logic [UP-1:0] s_uv;
    logic [RW-1:0] s_ur [UP];
    logic [CW-1:0] s_um [UP];
    logic [CW-1:0] s_ui [UP];
    logic          s_fv;
    logic [RW-1:0] s_fr;

    function automatic bit younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] != b[RW-1]) return a[RW-2:0] < b[RW-2:0];
        return a[RW-2:0] > b[RW-2:0];
    endfunction

    function automatic logic [CW-1:0] wake(input logic [RW-1:0] rob, input logic [CW-1:0] c);
        logic [CW-1:0] r;
        r = c;
        for (int u = 0; u < UP; u++)
            if (s_uv[u] && s_ur[u] == rob) r = (r & ~s_um[u]) | (s_ui[u] & s_um[u]);
        return r;
    endfunction

    function automatic logic [EP-1:0] model_enq_ready();
        logic [EP-1:0] r;
        for (int p = 0; p < EP; p++) r[p] = !s_fv && ((DEPTH - model.size()) > p);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r[DW-1:0];
    endfunction

    task automatic idle();
        s_ev = '0; s_dr = '0; s_uv = '0; s_fv = 1'b0; s_fr = '0;
        for (int p = 0; p < EP; p++) begin
            s_ed[p] = '0; s_ec[p] = '0; s_ei[p] = '0; s_er[p] = '0;
        end
        for (int u = 0; u < UP; u++) begin
            s_ur[u] = '0; s_um[u] = '0; s_ui[u] = '0;
        end
    endtask

    task automatic apply_inputs();
        for (int p = 0; p < EP; p++) begin
            enq_data[p*DW +: DW]      = s_ed[p];
            enq_condition[p*CW +: CW] = s_ec[p];
            enq_index[p*IW +: IW]     = s_ei[p];
            enq_robid[p*RW +: RW]     = s_er[p];
        end
        for (int u = 0; u < UP; u++) begin
            update_condition_robid[u*RW +: RW] = s_ur[u];
            update_condition_mask[u*CW +: CW]  = s_um[u];
            update_condition_in[u*CW +: CW]    = s_ui[u];
        end
        enq_valid              = s_ev;
        deq_ready              = s_dr;
        update_condition_valid = s_uv;
        flush_valid            = s_fv;
        flush_robid            = s_fr;
    endtask

    // Drive the stimulus and queue the model's view of this cycle.
    task automatic drive();
        exp_t e;
        int   k;
        apply_inputs();
        cur_ready   = model_enq_ready();
        e.enq_ready = cur_ready;
        e.count     = CNTW'(model.size());
        e.deq_valid = '0;
        e.rob = '0; e.data = '0; e.cond = '0; e.idx = '0;
        for (int q = 0; q < DP; q++) sel[q] = -1;
        k = 0;
        for (int i = 0; i < model.size(); i++) begin
            if ((&model[i].cond) && !(s_fv && younger(model[i].rob, s_fr))) begin
                if (k < DP) begin
                    sel[k]         = i;
                    e.deq_valid[k] = 1'b1;
                    e.rob[k]       = model[i].rob;
                    e.data[k]      = model[i].data;
                    e.cond[k]      = model[i].cond;
                    e.idx[k]       = model[i].idx;
                end
                k++;
            end
        end
        sb.push_back(e);
    endtask

    // Advance the model across the clock edge.
    task automatic tick();
        ent_t nq[$];
        ent_t ne;
        bit   gone;
        @(posedge clock);
        for (int i = 0; i < model.size(); i++) begin
            gone = s_fv && younger(model[i].rob, s_fr);
            for (int k = 0; k < DP; k++) if (sel[k] == i && s_dr[k]) gone = 1'b1;
            if (!gone) begin
                ne = model[i];
                ne.cond = wake(ne.rob, ne.cond);
                nq.push_back(ne);
            end
        end
        for (int p = 0; p < EP; p++) begin
            if (s_ev[p] && cur_ready[p]) begin
                ne.seq = seq; ne.rob = s_er[p]; ne.cond = wake(s_er[p], s_ec[p]);
                ne.data = s_ed[p]; ne.idx = s_ei[p];
                nq.push_back(ne);
            end
        end
        model = nq;
        #1;
    endtask

    task automatic cycle();
        drive();
        tick();
    endtask

    task automatic peek();
        @(negedge clock);
        #1;
    endtask

    task automatic set_enq(input int p, input logic [RW-1:0] rob, input logic [CW-1:0] cond);
        s_ev[p] = 1'b1; s_er[p] = rob; s_ec[p] = cond;
        s_ed[p] = rand_data(); s_ei[p] = IW'($urandom);
    endtask

    // Short reset between directed scenarios, away from clock edges.
    task automatic hard_reset();
        idle();
        apply_inputs();
        #1 reset_n = 1'b0;
        model.delete();
        #1 reset_n = 1'b1;
    endtask

    task automatic rand_cycle();
        int pick;
        idle();
        s_fv = (model.size() > 0) && ($urandom_range(0, 19) == 0);
        if (s_fv) begin
            pick = $urandom_range(0, model.size() - 1);
            s_fr = model[pick].rob;
        end
        cur_ready = model_enq_ready();
        for (int p = 0; p < EP; p++) begin
            s_ev[p] = ($urandom_range(0, 2) != 0);
            s_ed[p] = rand_data();
            s_ec[p] = CW'($urandom);
            s_ei[p] = IW'($urandom);
            if (s_ev[p] && cur_ready[p]) begin
                s_er[p] = RW'(seq);
                seq++;
            end else begin
                s_er[p] = RW'($urandom);
            end
        end
        s_dr = DP'($urandom);
        for (int u = 0; u < UP; u++) begin
            s_uv[u] = ($urandom_range(0, 3) != 0);
            s_um[u] = CW'($urandom);
            s_ui[u] = CW'($urandom);
            pick    = $urandom_range(0, 3);
            if (pick <= 1 && model.size() > 0) s_ur[u] = model[$urandom_range(0, model.size() - 1)].rob;
            else if (pick == 2)                s_ur[u] = s_er[0];
            else                               s_ur[u] = RW'($urandom);
        end
        // Keep the resident robid window well inside half the ROB range.
        if (model.size() > 0 && (seq - model[0].seq) > 40) begin
            s_uv[0] = 1'b1; s_ur[0] = model[0].rob; s_um[0] = '1; s_ui[0] = '1;
            s_dr[0] = 1'b1;
        end
        cycle();
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t me;
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            check("enq_ready", 256'(enq_ready), 256'(me.enq_ready));
            check("deq_valid", 256'(deq_valid), 256'(me.deq_valid));
            check("isq_count", 256'(isq_count), 256'(me.count));
            for (int k = 0; k < DP; k++) begin
                check($sformatf("deq_robid%0d", k), 256'(deq_robid[k*RW +: RW]), 256'(me.rob[k]));
                check($sformatf("deq_data%0d", k), 256'(deq_data[k*DW +: DW]), 256'(me.data[k]));
                check($sformatf("deq_cond%0d", k), 256'(deq_condition[k*CW +: CW]), 256'(me.cond[k]));
                check($sformatf("deq_index%0d", k), 256'(deq_index[k*IW +: IW]), 256'(me.idx[k]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        idle();
        apply_inputs();
        #12;
        check("rst_count", 256'(isq_count), 256'(0));
        check("rst_deq_valid", 256'(deq_valid), 256'(0));
        check("rst_enq_ready", 256'(enq_ready), 256'(2'b11));
        check("rst_deq_robid", 256'(deq_robid), 256'(0));
        #4 reset_n = 1'b1;   // posedge + 1

        // T2: fill 2 per cycle, nothing issued
        for (int c = 0; c < 4; c++) begin
            idle();
            set_enq(0, RW'(2*c), 2'b11);
            set_enq(1, RW'(2*c + 1), 2'b11);
            cycle();
        end
        idle();
        drive(); peek();
        check("t2_count", 256'(isq_count), 256'(8));
        check("t2_enq_ready", 256'(enq_ready), 256'(0));
        check("t2_deq0_rob", 256'(deq_robid[0 +: RW]), 256'(0));
        check("t2_deq1_rob", 256'(deq_robid[RW +: RW]), 256'(1));
        tick();
        // Full queue: a same-cycle issue gives no enqueue credit
        idle();
        s_dr = 2'b11; set_enq(0, RW'(8), 2'b11); set_enq(1, RW'(9), 2'b11);
        drive(); peek();
        check("t2_full_enq_ready", 256'(enq_ready), 256'(0));
        tick();
        idle(); drive(); peek();
        check("t2_after_deq_count", 256'(isq_count), 256'(6));
        tick();

        // T3: age order with a late wakeup of the oldest entry
        hard_reset();
        idle(); set_enq(0, RW'(5), 2'b01); cycle();
        idle(); set_enq(0, RW'(6), 2'b11); set_enq(1, RW'(7), 2'b11); cycle();
        idle(); s_uv[0] = 1'b1; s_ur[0] = RW'(5); s_um[0] = 2'b10; s_ui[0] = 2'b10;
        drive(); peek();
        check("t3_wake_cycle_deq0", 256'(deq_robid[0 +: RW]), 256'(6));
        check("t3_wake_cycle_deq1", 256'(deq_robid[RW +: RW]), 256'(7));
        tick();
        idle(); drive(); peek();
        check("t3_deq0", 256'(deq_robid[0 +: RW]), 256'(5));
        check("t3_deq1", 256'(deq_robid[RW +: RW]), 256'(6));
        tick();

        // T4: wakeup bypass onto an entry being enqueued
        hard_reset();
        idle(); set_enq(0, RW'(9), 2'b00);
        s_uv = 2'b11;
        s_ur[0] = RW'(9); s_um[0] = 2'b01; s_ui[0] = 2'b01;
        s_ur[1] = RW'(9); s_um[1] = 2'b10; s_ui[1] = 2'b10;
        cycle();
        idle(); drive(); peek();
        check("t4_deq_valid", 256'(deq_valid), 256'(2'b01));
        check("t4_deq0_rob", 256'(deq_robid[0 +: RW]), 256'(9));
        check("t4_deq0_cond", 256'(deq_condition[0 +: CW]), 256'(2'b11));
        tick();

        // T5: flush with concurrent issue of the survivors
        hard_reset();
        idle(); set_enq(0, RW'(3), 2'b11); set_enq(1, RW'(4), 2'b11); cycle();
        idle(); set_enq(0, RW'(5), 2'b11); set_enq(1, RW'(6), 2'b11); cycle();
        idle(); s_fv = 1'b1; s_fr = RW'(4); s_dr = 2'b11;
        set_enq(0, RW'(7), 2'b11); set_enq(1, RW'(8), 2'b11);
        drive(); peek();
        check("t5_deq0", 256'(deq_robid[0 +: RW]), 256'(3));
        check("t5_deq1", 256'(deq_robid[RW +: RW]), 256'(4));
        check("t5_flush_enq_ready", 256'(enq_ready), 256'(0));
        tick();
        idle(); drive(); peek();
        check("t5_count", 256'(isq_count), 256'(0));
        check("t5_enq_ready", 256'(enq_ready), 256'(2'b11));
        tick();

        // T6: wrap-bit ordering; second entry arrives on port 1 alone
        hard_reset();
        idle(); set_enq(0, RW'(7'h3E), 2'b11); cycle();
        idle(); set_enq(1, RW'(7'h41), 2'b11); cycle();
        idle(); drive(); peek();
        check("t6_deq0", 256'(deq_robid[0 +: RW]), 256'(7'h3E));
        check("t6_deq1", 256'(deq_robid[RW +: RW]), 256'(7'h41));
        tick();
        idle(); s_fv = 1'b1; s_fr = RW'(7'h3F);
        drive(); peek();
        check("t6_flush_deq_valid", 256'(deq_valid), 256'(2'b01));
        tick();
        idle(); drive(); peek();
        check("t6_count", 256'(isq_count), 256'(1));
        check("t6_survivor", 256'(deq_robid[0 +: RW]), 256'(7'h3E));
        tick();

        // Randomized traffic against the model
        hard_reset();
        seq = 0;
        for (int c = 0; c < 3000; c++) rand_cycle();

        // T1: asynchronous reset in the middle of traffic
        idle();
        set_enq(0, RW'(seq), 2'b11); set_enq(1, RW'(seq + 1), 2'b11);
        s_dr = 2'b11;
        apply_inputs();
        #1 reset_n = 1'b0;
        model.delete();
        @(posedge clock);
        #1;
        check("t1_count", 256'(isq_count), 256'(0));
        check("t1_deq_valid", 256'(deq_valid), 256'(0));
        check("t1_enq_ready", 256'(enq_ready), 256'(2'b11));
        reset_n = 1'b1;
        for (int c = 0; c < 200; c++) rand_cycle();

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
